microwave_cook_ctrl: RTL and testbench
======================================

Name: microwave_cook_ctrl

Overview:
Cook-cycle sequencer for the microwave. It collects keypad digits into an MM:SS BCD time and counts that time down at 1 Hz while heating. It handles pause/resume, cancel and door-open interlock, then runs an end-of-cook beep sequence. It drives magnetron enable, the display digits, and a one-cycle timer_end pulse consumed by the start/idle button logic.

Parameters:
TICK_DIV, 100_000_000, clk cycles per 1 s tick (>=2)
BEEP_SECS, 3, seconds beep stays asserted in DONE (1..15)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
digit_vld  in  1  one-cycle strobe, keypad digit available
digit  in  4  BCD keypad value; 10..15 ignored
start_req  in  1  one-cycle start/pause-toggle strobe (button or keyboard)
cancel_req  in  1  one-cycle cancel strobe
door_open  in  1  level, door interlock
time_bcd  out  16  {M1,M0,S1,S0} remaining/entered time
heating  out  1  magnetron enable
paused  out  1  high in PAUSE
beep  out  1  buzzer enable
timer_end  out  1  one-cycle pulse on COOK->DONE
state  out  3  FSM state code for display/debug

Behaviour:
- Reset (rst=0, async): state=IDLE, time_bcd=0000, prescaler=0, beep counter=0, all 1-bit outputs 0.
- States/codes: IDLE=0, ENTRY=1, COOK=2, PAUSE=3, DONE=4.
- Priority per cycle: door_open > cancel_req > start_req > digit_vld. Only the highest-priority event acts; lower-priority strobes in the same cycle are dropped.
- IDLE: valid digit -> time_bcd={000,digit}, go ENTRY. start_req, cancel_req ignored.
- ENTRY: valid digit shifts left (time_bcd <= {time_bcd[11:0],digit}). The oldest digit drops after 4 entries. cancel -> time=0000, IDLE. start_req with time!=0000 and door closed -> COOK, prescaler cleared. start_req with time=0000 or door open -> ignored.
- COOK: heating=1. The prescaler counts 0..TICK_DIV-1; the tick occurs on the cycle it equals TICK_DIV-1, and it wraps to 0.
- Tick decrement: if S!=00, S-=1 in BCD (S0 borrows into S1). If S=00 and M!=00, M-=1 and S=59. SS entered above 59 (e.g. 0:90) counts straight down, not normalized.
- Tick when time=0001 or 0100->0059 etc.: ordinary. Tick producing 0000 -> go DONE the same edge; timer_end=1 for exactly that next cycle; heating=0 from that cycle.
- COOK: door_open, cancel_req or start_req -> PAUSE. heating drops the next cycle. A tick on that same cycle is discarded. The prescaler holds its value; a partial second is preserved.
- PAUSE: paused=1, heating=0. start_req with door closed -> COOK, prescaler resumes. cancel_req -> time=0000, IDLE. Digits ignored.
- DONE: beep=1, time_bcd=0000. Stays BEEP_SECS ticks, using the prescaler free-running from 0. It then goes IDLE. cancel_req or door_open ends DONE immediately -> IDLE, beep=0 next cycle.
- Digits with value >9 never alter time_bcd.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
QUICK_ADD_EN. When defined: start_req in COOK adds 30 s instead of pausing. On S overflow past 59, carry into M (S-=60, M+=1). Saturate at 99:59. start_req in IDLE loads 0030 and enters COOK directly. When undefined: start_req in COOK pauses and start_req in IDLE is ignored, as above.

Test Plan:
- Reset mid-COOK (time 0125) -> next clk: state=0, time_bcd=0000, heating=0, beep=0, independent of clk edge.
- Digits 1,3,0 then start (TICK_DIV=4) -> COOK. Sequence 0130, 0129 ... 0100, 0059 ... 0000. One timer_end pulse, heating falls same cycle. beep high exactly 3*4 cycles, then IDLE.
- Digits 4,5,6,7,8 -> time_bcd=5678; digit 11 -> unchanged; start with time=0000 from fresh ENTRY via digit 0 -> stays ENTRY.
- COOK at 0010, prescaler=2, door_open=1 -> PAUSE, heating 0. Start while door open -> ignored. Close door, start -> resumes; next tick after 1 more cycle (TICK_DIV=4) -> 0009.
- Same-cycle cancel_req+start_req in COOK -> PAUSE once (no double toggle). cancel in PAUSE -> IDLE, 0000. cancel in DONE -> beep 0 next cycle.
- QUICK_ADD_EN: COOK at 0045, start -> 0115. At 9945 -> 9959 saturate. IDLE start -> COOK at 0030.

Source files
------------

// File: rtl/microwave_cook_ctrl.sv
// Microwave cook-cycle sequencer: keypad MM:SS entry, 1 Hz BCD countdown, pause/cancel/door interlock, end beep.
// Optional QUICK_ADD_EN: start_req adds 30 s while cooking and starts a 0:30 cook from IDLE.
module microwave_cook_ctrl #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int BEEP_SECS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        digit_vld,
  input  logic [3:0]  digit,
  input  logic        start_req,
  input  logic        cancel_req,
  input  logic        door_open,
  output logic [15:0] time_bcd,
  output logic        heating,
  output logic        paused,
  output logic        beep,
  output logic        timer_end,
  output logic [2:0]  state
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ENTRY = 3'd1;
  localparam logic [2:0] ST_COOK  = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX   = PW'(TICK_DIV - 1);
  localparam logic [3:0]    BEEP_LAST = 4'(BEEP_SECS - 1);

  // Inputs are single-cycle strobes (door_open is a level); there is no
  // back-pressure. When several arrive together only the highest-priority one
  // (door_open > cancel_req > start_req > digit_vld) acts, the rest are dropped.

  logic [PW-1:0] prescaler, pre_nxt;
  logic [3:0]    beep_cnt, bcnt_nxt;
  logic [2:0]    state_nxt;
  logic [15:0]   time_nxt;
  logic          done_evt;
  logic          tick;
  logic          digit_ok;

  assign tick     = (prescaler == PRE_MAX);
  assign digit_ok = digit_vld && (digit <= 4'd9);

  // Two-digit BCD minus one; caller guarantees v != 00.
  function automatic logic [7:0] bcd_dec2(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] != 4'd0) r = {v[7:4], v[3:0] - 4'd1};
    else                r = {v[7:4] - 4'd1, 4'd9};
    return r;
  endfunction

  // Seconds borrow from minutes; unnormalized SS (e.g. 90) just counts down.
  function automatic logic [15:0] time_dec(input logic [15:0] t);
    logic [15:0] r;
    if (t[7:0] != 8'h00)       r = {t[15:8], bcd_dec2(t[7:0])};
    else if (t[15:8] != 8'h00) r = {bcd_dec2(t[15:8]), 8'h59};
    else                       r = 16'h0000;
    return r;
  endfunction

`ifdef QUICK_ADD_EN
  function automatic logic [7:0] bcd2bin(input logic [7:0] v);
    return 8'(v[7:4]) * 8'd10 + 8'(v[3:0]);
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [7:0] b);
    return {4'(b / 8'd10), 4'(b % 8'd10)};
  endfunction

  // +30 s with a single carry into minutes, saturating at 99:59.
  function automatic logic [15:0] time_add30(input logic [15:0] t);
    logic [7:0]  s2;
    logic [7:0]  m2;
    logic [15:0] r;
    s2 = bcd2bin(t[7:0]) + 8'd30;
    m2 = bcd2bin(t[15:8]);
    if (s2 >= 8'd60) begin
      s2 = s2 - 8'd60;
      m2 = m2 + 8'd1;
    end
    if (m2 > 8'd99) r = 16'h9959;
    else            r = {bin2bcd(m2), bin2bcd(s2)};
    return r;
  endfunction
`endif

  always_comb begin
    state_nxt = state;
    time_nxt  = time_bcd;
    pre_nxt   = prescaler;
    bcnt_nxt  = beep_cnt;
    done_evt  = 1'b0;
    case (state)
      ST_IDLE: begin
`ifdef QUICK_ADD_EN
        if (!cancel_req && start_req && !door_open) begin
          time_nxt  = 16'h0030;
          pre_nxt   = '0;
          state_nxt = ST_COOK;
        end else if (!cancel_req && !start_req && digit_ok) begin
          time_nxt  = {12'h000, digit};
          state_nxt = ST_ENTRY;
        end
`else
        if (!cancel_req && !start_req && digit_ok) begin
          time_nxt  = {12'h000, digit};
          state_nxt = ST_ENTRY;
        end
`endif
      end
      ST_ENTRY: begin
        if (cancel_req) begin
          time_nxt  = 16'h0000;
          state_nxt = ST_IDLE;
        end else if (start_req) begin
          if (time_bcd != 16'h0000 && !door_open) begin
            pre_nxt   = '0;
            state_nxt = ST_COOK;
          end
        end else if (digit_ok) begin
          time_nxt = {time_bcd[11:0], digit};
        end
      end
      ST_COOK: begin
        // Pausing freezes the prescaler so the partial second survives.
`ifdef QUICK_ADD_EN
        if (door_open || cancel_req) begin
          state_nxt = ST_PAUSE;
        end else if (start_req) begin
          time_nxt = time_add30(time_bcd);
          pre_nxt  = tick ? '0 : prescaler + PW'(1);
        end else
`else
        if (door_open || cancel_req || start_req) begin
          state_nxt = ST_PAUSE;
        end else
`endif
        if (tick) begin
          pre_nxt  = '0;
          time_nxt = time_dec(time_bcd);
          if (time_nxt == 16'h0000) begin
            state_nxt = ST_DONE;
            bcnt_nxt  = '0;
            done_evt  = 1'b1;
          end
        end else begin
          pre_nxt = prescaler + PW'(1);
        end
      end
      ST_PAUSE: begin
        if (cancel_req) begin
          time_nxt  = 16'h0000;
          state_nxt = ST_IDLE;
        end else if (start_req && !door_open) begin
          state_nxt = ST_COOK;
        end
      end
      ST_DONE: begin
        time_nxt = 16'h0000;
        if (door_open || cancel_req) begin
          pre_nxt   = '0;
          bcnt_nxt  = '0;
          state_nxt = ST_IDLE;
        end else if (tick) begin
          pre_nxt = '0;
          if (beep_cnt == BEEP_LAST) begin
            bcnt_nxt  = '0;
            state_nxt = ST_IDLE;
          end else begin
            bcnt_nxt = beep_cnt + 4'd1;
          end
        end else begin
          pre_nxt = prescaler + PW'(1);
        end
      end
      default: begin
        time_nxt  = 16'h0000;
        pre_nxt   = '0;
        bcnt_nxt  = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      time_bcd  <= 16'h0000;
      prescaler <= '0;
      beep_cnt  <= '0;
      heating   <= 1'b0;
      paused    <= 1'b0;
      beep      <= 1'b0;
      timer_end <= 1'b0;
    end else begin
      state     <= state_nxt;
      time_bcd  <= time_nxt;
      prescaler <= pre_nxt;
      beep_cnt  <= bcnt_nxt;
      heating   <= (state_nxt == ST_COOK);
      paused    <= (state_nxt == ST_PAUSE);
      beep      <= (state_nxt == ST_DONE);
      timer_end <= done_evt;
    end
  end

endmodule

// File: tb/tb_microwave_cook_ctrl.sv
// Directed bench for microwave_cook_ctrl with TICK_DIV=4, BEEP_SECS=3.
// Quick-add checks are compiled in only when QUICK_ADD_EN is defined.
module tb_microwave_cook_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int BEEP_SECS = 3;
  localparam int NVEC      = 20;

  logic        clk;
  logic        rst;
  logic        digit_vld;
  logic [3:0]  digit;
  logic        start_req;
  logic        cancel_req;
  logic        door_open;
  logic [15:0] time_bcd;
  logic        heating;
  logic        paused;
  logic        beep;
  logic        timer_end;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic        dv;
    logic [3:0]  d;
    logic        st;
    logic        cn;
    logic        dr;
    logic [2:0]  e_state;
    logic [15:0] e_time;
    logic        e_heat;
  } vec_t;

  vec_t vecs[NVEC];

  microwave_cook_ctrl #(.TICK_DIV(TICK_DIV), .BEEP_SECS(BEEP_SECS)) dut (
    .clk(clk), .rst(rst), .digit_vld(digit_vld), .digit(digit),
    .start_req(start_req), .cancel_req(cancel_req), .door_open(door_open),
    .time_bcd(time_bcd), .heating(heating), .paused(paused), .beep(beep),
    .timer_end(timer_end), .state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    digit_vld = 1'b0; digit = 4'd0; start_req = 1'b0; cancel_req = 1'b0; door_open = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic press_digit(input logic [3:0] d);
    digit_vld = 1'b1; digit = d;
    step();
    digit_vld = 1'b0; digit = 4'd0;
  endtask

  task automatic press_start();
    start_req = 1'b1;
    step();
    start_req = 1'b0;
  endtask

  task automatic press_cancel();
    cancel_req = 1'b1;
    step();
    cancel_req = 1'b0;
  endtask

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] es, input logic [15:0] et,
                           input logic eh, input logic ep, input logic eb, input logic ee);
    check({tag, ".state"}, 32'(state), 32'(es));
    check({tag, ".time"}, 32'(time_bcd), 32'(et));
    check({tag, ".heating"}, 32'(heating), 32'(eh));
    check({tag, ".paused"}, 32'(paused), 32'(ep));
    check({tag, ".beep"}, 32'(beep), 32'(eb));
    check({tag, ".timer_end"}, 32'(timer_end), 32'(ee));
  endtask

  function automatic logic [15:0] secs_to_bcd(input int secs);
    int m;
    int s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  initial begin
    int te_cnt;
    int bc;
    logic [15:0] exp_t;

    //            dv    d      st    cn    dr    state  time      heat
    vecs[0]  = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 4'd4,  1'b0, 1'b0, 1'b0, 3'd1, 16'h0004, 1'b0};
    vecs[2]  = '{1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 3'd1, 16'h0045, 1'b0};
    vecs[3]  = '{1'b1, 4'd6,  1'b0, 1'b0, 1'b0, 3'd1, 16'h0456, 1'b0};
    vecs[4]  = '{1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 3'd1, 16'h4567, 1'b0};
    vecs[5]  = '{1'b1, 4'd8,  1'b0, 1'b0, 1'b0, 3'd1, 16'h5678, 1'b0};
    vecs[6]  = '{1'b1, 4'd11, 1'b0, 1'b0, 1'b0, 3'd1, 16'h5678, 1'b0};
    vecs[7]  = '{1'b1, 4'd9,  1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0};
    vecs[8]  = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 3'd1, 16'h0000, 1'b0};
    vecs[9]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 3'd1, 16'h0000, 1'b0};
    vecs[10] = '{1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 3'd1, 16'h0001, 1'b0};
    vecs[11] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 3'd1, 16'h0001, 1'b0};
    vecs[12] = '{1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 3'd1, 16'h0001, 1'b0};
    vecs[13] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0};
    vecs[14] = '{1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0};
    vecs[15] = '{1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 3'd1, 16'h0007, 1'b0};
    vecs[16] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 3'd2, 16'h0007, 1'b1};
    vecs[17] = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 3'd3, 16'h0007, 1'b0};
    vecs[18] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 3'd3, 16'h0007, 1'b0};
    vecs[19] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0};

    rst = 1'b0;
    idle_inputs();
    #2;
    check_all("reset", 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    check_all("post_reset", 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // table-driven entry / start / cancel vectors
    for (int i = 0; i < NVEC; i++) begin
      digit_vld = vecs[i].dv; digit = vecs[i].d; start_req = vecs[i].st;
      cancel_req = vecs[i].cn; door_open = vecs[i].dr;
      step();
      idle_inputs();
      check($sformatf("vec%0d.state", i), 32'(state), 32'(vecs[i].e_state));
      check($sformatf("vec%0d.time", i), 32'(time_bcd), 32'(vecs[i].e_time));
      check($sformatf("vec%0d.heating", i), 32'(heating), 32'(vecs[i].e_heat));
    end

    // full cook from 1:30 down to DONE, then the beep window
    do_reset();
    press_digit(4'd1);
    press_digit(4'd3);
    press_digit(4'd0);
    check("entry_0130", 32'(time_bcd), 32'h0130);
    press_start();
    check_all("cook_start", 3'd2, 16'h0130, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int e = 1; e <= 90 * TICK_DIV; e++) exp_q.push_back(secs_to_bcd(90 - e / TICK_DIV));
    te_cnt = 0;
    for (int e = 1; e <= 90 * TICK_DIV; e++) begin
      step();
      exp_t = exp_q.pop_front();
      if (timer_end) te_cnt++;
      check($sformatf("cook_e%0d.time", e), 32'(time_bcd), 32'(exp_t));
      check($sformatf("cook_e%0d.heating", e), 32'(heating), (e < 90 * TICK_DIV) ? 32'd1 : 32'd0);
    end
    check_all("cook_done", 3'd4, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
    bc = 1;
    for (int i = 0; i < 40 && state != 3'd0; i++) begin
      step();
      if (beep) bc++;
      if (timer_end) te_cnt++;
    end
    check("beep_cycles", 32'(bc), 32'(BEEP_SECS * TICK_DIV));
    check("done_to_idle", 32'(state), 32'd0);
    check("timer_end_pulses", 32'(te_cnt), 32'd1);

    // door interlock pause, resume with preserved partial second
    do_reset();
    press_digit(4'd1);
    press_digit(4'd0);
    press_start();
    step();
    step();
    door_open = 1'b1;
    step();
    check_all("door_pause", 3'd3, 16'h0010, 1'b0, 1'b1, 1'b0, 1'b0);
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    check("start_door_open", 32'(state), 32'd3);
    door_open = 1'b0;
    press_start();
    check_all("resume", 3'd2, 16'h0010, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("resume_pre3", 32'(time_bcd), 32'h0010);
    step();
    check("resume_tick", 32'(time_bcd), 32'h0009);
    step();
    step();
    step();
    press_cancel();
    check_all("cancel_pause", 3'd3, 16'h0009, 1'b0, 1'b1, 1'b0, 1'b0);
    press_start();
    check("resume2", 32'(state), 32'd2);
    cancel_req = 1'b1; start_req = 1'b1;
    step();
    idle_inputs();
    check_all("cancel_start_cook", 3'd3, 16'h0009, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check("no_double_toggle", 32'(state), 32'd3);
    press_start();
    step();
    check("held_tick", 32'(time_bcd), 32'h0008);
    press_cancel();
    press_cancel();
    check_all("pause_cancel", 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // cancel / door ending DONE early
    do_reset();
    press_digit(4'd2);
    press_start();
    repeat (2 * TICK_DIV) step();
    check_all("done2", 3'd4, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
    press_cancel();
    check_all("done_cancel", 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    press_digit(4'd1);
    press_start();
    repeat (TICK_DIV) step();
    step();
    check_all("done1", 3'd4, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    door_open = 1'b1;
    step();
    door_open = 1'b0;
    check_all("done_door", 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // asynchronous reset between clock edges while cooking
    press_digit(4'd1);
    press_digit(4'd2);
    press_digit(4'd5);
    press_start();
    repeat (5) step();
    check("pre_async", 32'(time_bcd), 32'h0124);
    #3;
    rst = 1'b0;
    #1;
    check_all("async_rst", 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    step();
    check("after_rst", 32'(state), 32'd0);

`ifdef QUICK_ADD_EN
    do_reset();
    press_start();
    check_all("qa_idle", 3'd2, 16'h0030, 1'b1, 1'b0, 1'b0, 1'b0);
    press_cancel();
    press_cancel();
    press_digit(4'd4);
    press_digit(4'd5);
    press_start();
    press_start();
    check_all("qa_0045", 3'd2, 16'h0115, 1'b1, 1'b0, 1'b0, 1'b0);
    press_cancel();
    press_cancel();
    press_digit(4'd9);
    press_digit(4'd9);
    press_digit(4'd4);
    press_digit(4'd5);
    press_start();
    press_start();
    check_all("qa_sat", 3'd2, 16'h9959, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
